pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
Servo-PWM input decoder. It sits downstream of the servo PWM generator, or on an external servo-signal pin, and measures the active pulse width in 10 us ticks. It converts that width back into the 7-bit duty code used by the generator: 0 means a 1.0 ms pulse, 100 means a 2.0 ms pulse. It also flags malformed pulses and loss of signal, which enables loop-back testing of the generator.

Parameters:
PRESCALER_MAX, 119, clk cycles per tick minus 1 (12 MHz clock gives a 10 us tick).
MIN_TICKS, 50, shortest accepted pulse in ticks (0.5 ms).
MAX_TICKS, 250, longest accepted pulse in ticks (2.5 ms).
LOSS_TICKS, 2500, ticks without a rising edge before signal_lost is set (25 ms).

Ports:
clk  in  1  system clock, 12 MHz.
rst_n  in  1  synchronous, active-low reset.
pwm_in  in  1  asynchronous PWM input.
invert_polarity  in  1  1 = active-low input pulse.
dc_out  out  7  last accepted duty code, 0..100.
dc_valid  out  1  one-cycle strobe; dc_out was updated this cycle.
pulse_err  out  1  one-cycle strobe; a completed pulse was rejected.
signal_lost  out  1  level; no valid signal.

Behaviour:
- Input conditioning:
  - lvl = pwm_in XOR invert_polarity.
  - lvl passes a 2-flop synchronizer plus a history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Synchronizer and history flops reset to 0.
- Reset values: dc_out=0, dc_valid=0, pulse_err=0, signal_lost=1, state=ARM, all counters 0.
- State ARM:
  - Waits until the synchronized level is low, then moves to IDLE.
  - A pulse already high when reset is released is never measured.
- State IDLE:
  - On rise: clear the prescaler and the width counter, clear the loss counter, go to HIGH.
- State HIGH:
  - Prescaler counts 0..PRESCALER_MAX; on wrap the width counter increments.
  - Width counter is 8 bits and saturates at 255.
  - On fall: ticks = width + (prescaler >= (PRESCALER_MAX+1)/2 ? 1 : 0), i.e. rounded to the nearest tick. Go to IDLE.
  - Equivalently, ticks = floor((C + 60)/120), where C = clk cycles from rise detect to fall detect.
- Acceptance when MIN_TICKS <= ticks <= MAX_TICKS:
  - dc_out = clamp(ticks - 100, 0, 100).
  - dc_valid=1 for one cycle; signal_lost cleared in the same cycle.
  - Otherwise pulse_err=1 for one cycle; dc_out, dc_valid and signal_lost are unchanged.
- Latency: dc_valid / pulse_err are registered and assert exactly 3 clk edges after the first edge that samples pwm_in at its post-fall level.
- Loss counter:
  - 12 bits, ticks from a free-running prescaler, cleared on every rise, saturating.
  - When it reaches LOSS_TICKS: signal_lost=1, state goes to ARM, and any in-progress measurement is discarded with no strobe.
  - Covers both a stuck-low and a stuck-high input.
- Simultaneous events: rise in the same cycle as loss expiry means the rise wins; the counter clears and signal_lost is unchanged.
- Toggling invert_polarity creates an edge. It is treated as a normal edge; resulting short or long pulses are rejected via pulse_err.
- rst_n low mid-pulse: return to reset values immediately; no strobe.
- dc_valid and pulse_err are never asserted in the same cycle.

Test Plan:
1. Reset release with pwm_in=1 for 1.5 ms, then normal 20 ms frames of 1.5 ms high (18000 cycles) -> first partial pulse ignored; next frame gives dc_valid once, dc_out=50, signal_lost 1->0.
2. Pulses of 1.0 ms and 2.0 ms (12000 / 24000 cycles), including +/-59-cycle jitter -> dc_out=0 and dc_out=100 respectively; one dc_valid per pulse.
3. Pulses of 0.9 ms and 2.2 ms (90 / 220 ticks) -> accepted with clamping: dc_out=0, dc_out=100. Pulses of 0.4 ms and 2.6 ms -> pulse_err strobe, dc_out holds its previous value.
4. invert_polarity=1 with an active-low 1.25 ms pulse -> dc_out=25. Drive pwm_in constant for 25 ms -> signal_lost=1 exactly when the loss counter reaches 2500 ticks; no strobe.
5. Loopback from the PWM generator with codes 0, 37, 100, and with the generator's invert_polarity set to match -> dc_out equals each code, one dc_valid per 20 ms frame.
6. Assert rst_n low mid-pulse for 1 cycle -> all outputs return to reset values; the remainder of the pulse is ignored (ARM); the next full pulse is measured correctly.

Source files
------------

// File: rtl/pwm_capture.sv
// Servo PWM input decoder: measures the active pulse width in prescaler ticks and
// converts it to a 0..100 duty code, with pulse-reject and loss-of-signal flags.
module pwm_capture #(
  parameter int PRESCALER_MAX = 119,
  parameter int MIN_TICKS     = 50,
  parameter int MAX_TICKS     = 250,
  parameter int LOSS_TICKS    = 2500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  input  logic       invert_polarity,
  output logic [6:0] dc_out,
  output logic       dc_valid,
  output logic       pulse_err,
  output logic       signal_lost
);

  localparam int PW = (PRESCALER_MAX > 0) ? $clog2(PRESCALER_MAX + 1) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(PRESCALER_MAX);
  localparam logic [PW-1:0] ROUND_AT  = PW'(PRESCALER_MAX - (PRESCALER_MAX + 1) / 2);
  localparam logic [8:0]    MIN_T     = 9'(MIN_TICKS);
  localparam logic [8:0]    MAX_T     = 9'(MAX_TICKS);
  localparam logic [11:0]   LOSS_LAST = 12'(LOSS_TICKS - 1);

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t        state;
  logic          lvl;
  logic          sync_meta;
  logic          sync_lvl;
  logic          hist;
  logic          rise;
  logic          fall;
  logic [1:0]    fill;
  logic [PW-1:0] presc;
  logic [PW-1:0] free_presc;
  logic [7:0]    width;
  logic [11:0]   loss_cnt;
  logic          loss_tick;
  logic          loss_expire;
  logic [8:0]    ticks;
  logic          accept;
  logic [6:0]    code;

  assign lvl         = pwm_in ^ invert_polarity;
  assign rise        = sync_lvl & ~hist;
  assign fall        = ~sync_lvl & hist;
  assign loss_tick   = (free_presc == PRESC_TOP);
  assign loss_expire = loss_tick & ~rise & (loss_cnt == LOSS_LAST);

  // The fall cycle itself is not yet counted in presc, so round one count early.
  assign ticks  = {1'b0, width} + {8'd0, (presc >= ROUND_AT)};
  assign accept = (ticks >= MIN_T) && (ticks <= MAX_T);

  always_comb begin
    code = 7'd0;
    if (ticks > 9'd200) begin
      code = 7'd100;
    end else if (ticks > 9'd100) begin
      code = 7'(ticks - 9'd100);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ARM;
      sync_meta   <= 1'b0;
      sync_lvl    <= 1'b0;
      hist        <= 1'b0;
      fill        <= 2'd0;
      presc       <= '0;
      free_presc  <= '0;
      width       <= 8'd0;
      loss_cnt    <= 12'd0;
      dc_out      <= 7'd0;
      dc_valid    <= 1'b0;
      pulse_err   <= 1'b0;
      signal_lost <= 1'b1;
    end else begin
      sync_meta <= lvl;
      sync_lvl  <= sync_meta;
      hist      <= sync_lvl;
      dc_valid  <= 1'b0;
      pulse_err <= 1'b0;

      // fill marks when sync_lvl first reflects the post-reset input
      if (fill != 2'd2) begin
        fill <= fill + 2'd1;
      end

      free_presc <= loss_tick ? '0 : free_presc + 1'b1;
      if (rise) begin
        loss_cnt <= 12'd0;
      end else if (loss_tick && (loss_cnt != 12'hfff)) begin
        loss_cnt <= loss_cnt + 12'd1;
      end

      if (loss_expire) begin
        signal_lost <= 1'b1;
        state       <= ARM;
      end else begin
        case (state)
          ARM: begin
            if ((fill == 2'd2) && !sync_lvl) begin
              state <= IDLE;
            end
          end
          IDLE: begin
            if (rise) begin
              presc <= '0;
              width <= 8'd0;
              state <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              if (accept) begin
                dc_out      <= code;
                dc_valid    <= 1'b1;
                signal_lost <= 1'b0;
              end else begin
                pulse_err <= 1'b1;
              end
              state <= IDLE;
            end else if (presc == PRESC_TOP) begin
              presc <= '0;
              if (width != 8'hff) begin
                width <= width + 8'd1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          default: state <= ARM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed and random pulses against a width-to-code model,
// with a shortened tick so each frame stays a few hundred cycles long.
module tb_pwm_capture;

  localparam int P     = 3;
  localparam int TICK  = P + 1;
  localparam int HALF  = TICK / 2;
  localparam int MIN_T = 50;
  localparam int MAX_T = 250;
  localparam int LOSS  = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic       invert_polarity = 1'b0;
  logic [6:0] dc_out;
  logic       dc_valid;
  logic       pulse_err;
  logic       signal_lost;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;
  int n_strobe = 0;
  int n_both = 0;
  int exp_dc = 0;
  bit exp_lost = 1'b1;
  bit armed = 1'b0;
  bit level = 1'b0;
  int last_rise = 0;

  pwm_capture #(
    .PRESCALER_MAX(P),
    .MIN_TICKS(MIN_T),
    .MAX_TICKS(MAX_T),
    .LOSS_TICKS(LOSS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwm_in(pwm_in),
    .invert_polarity(invert_polarity),
    .dc_out(dc_out),
    .dc_valid(dc_valid),
    .pulse_err(pulse_err),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the free-running tick wraps on multiples of TICK.
  always @(posedge clk) edge_no <= rst_n ? edge_no + 1 : 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (dc_valid === 1'b1 || pulse_err === 1'b1) n_strobe++;
    if (dc_valid === 1'b1 && pulse_err === 1'b1) n_both++;
  endtask

  task automatic set_lvl(input bit v);
    level  = v;
    pwm_in = v ^ invert_polarity;
  endtask

  task automatic set_inv(input bit v);
    invert_polarity = v;
    pwm_in = level ^ v;
  endtask

  function automatic int expect_code(input int t);
    if (t < 100) return 0;
    if (t > 200) return 100;
    return t - 100;
  endfunction

  // Ends a pulse of n active cycles and checks the strobe three edges later.
  task automatic tail(input string tag, input int n, input int gap, input bit measured);
    int s0;
    int t;
    bit acc;
    t   = (n + HALF) / TICK;
    acc = measured && (t >= MIN_T) && (t <= MAX_T);
    s0  = n_strobe;
    set_lvl(1'b0);
    step();
    step();
    check({tag, "_early"}, n_strobe - s0, 0);
    step();
    check({tag, "_valid"}, dc_valid, acc);
    check({tag, "_err"}, pulse_err, measured && !acc);
    if (acc) begin
      exp_dc   = expect_code(t);
      exp_lost = 1'b0;
    end
    check({tag, "_dc"}, dc_out, exp_dc);
    check({tag, "_lost"}, signal_lost, exp_lost);
    armed = 1'b1;
    repeat (gap - 3) step();
    check({tag, "_count"}, n_strobe - s0, measured ? 1 : 0);
  endtask

  task automatic pulse(input string tag, input int n, input int gap);
    int s0;
    bit measured;
    measured  = armed;
    last_rise = edge_no + 3;
    s0 = n_strobe;
    set_lvl(1'b1);
    repeat (n) step();
    check({tag, "_high"}, n_strobe - s0, 0);
    tail(tag, n, gap, measured);
  endtask

  // signal_lost must rise on the LOSS-th tick wrap after the last rise clear.
  task automatic wait_loss(input string tag);
    int l_edge;
    int guard;
    int s0;
    s0 = n_strobe;
    l_edge = (last_rise / TICK + 1) * TICK + (LOSS - 1) * TICK;
    guard = 0;
    while (edge_no < l_edge - 1 && guard < 2 * LOSS * TICK) begin
      step();
      guard++;
    end
    check({tag, "_reach"}, edge_no, l_edge - 1);
    check({tag, "_before"}, signal_lost, 0);
    step();
    check({tag, "_at"}, signal_lost, 1);
    check({tag, "_nostrobe"}, n_strobe - s0, 0);
    exp_lost = 1'b1;
    if (level) armed = 1'b0;
  endtask

  task automatic do_reset(input bit v);
    rst_n = 1'b0;
    set_lvl(v);
    repeat (3) step();
    check("rst_dc", dc_out, 0);
    check("rst_valid", dc_valid, 0);
    check("rst_err", pulse_err, 0);
    check("rst_lost", signal_lost, 1);
    rst_n = 1'b1;
    exp_dc   = 0;
    exp_lost = 1'b1;
    armed    = !v;
    repeat (8) step();
  endtask

  initial begin
    int bnd[10];
    int codes[3];
    int t;
    int jit;
    bnd   = '{360, 880, 160, 1040, 197, 198, 1001, 1002, 403, 804};
    codes = '{0, 37, 100};

    // Reset released mid-pulse: that pulse is ignored, the next frame is measured.
    do_reset(1'b1);
    repeat (592) step();
    tail("partial", 600, 30, 1'b0);
    pulse("frame1", 600, 40);
    pulse("frame2", 600, 40);

    // Nominal endpoints with +/- one cycle of jitter.
    pulse("p1ms", 400, 30);
    pulse("p1ms_m", 399, 30);
    pulse("p1ms_p", 401, 30);
    pulse("p2ms", 800, 30);
    pulse("p2ms_m", 799, 30);
    pulse("p2ms_p", 801, 30);

    // Clamping, rejection and acceptance-window edges.
    foreach (bnd[i]) pulse("bnd", bnd[i], 30);

    // Inverted input, then stuck-inactive and stuck-active loss.
    set_inv(1'b1);
    pulse("inv", 500, 30);
    wait_loss("stuck_lo");
    pulse("inv_rec", 600, 30);
    last_rise = edge_no + 3;
    set_lvl(1'b1);
    wait_loss("stuck_hi");
    repeat (40) step();
    tail("stuck_hi_end", 0, 20, 1'b0);
    set_inv(1'b0);
    pulse("rec2", 720, 30);

    // Generator loopback at both polarities.
    for (int inv = 0; inv < 2; inv++) begin
      set_inv(inv[0]);
      foreach (codes[i]) begin
        pulse("lb", (100 + codes[i]) * TICK, 60);
        check("lb_code", dc_out, codes[i]);
      end
    end
    set_inv(1'b0);

    // One-cycle reset in the middle of a pulse.
    pulse("pre_rst", 540, 30);
    set_lvl(1'b1);
    repeat (200) step();
    rst_n = 1'b0;
    step();
    check("mid_rst_dc", dc_out, 0);
    check("mid_rst_valid", dc_valid, 0);
    check("mid_rst_err", pulse_err, 0);
    check("mid_rst_lost", signal_lost, 1);
    rst_n = 1'b1;
    exp_dc   = 0;
    exp_lost = 1'b1;
    armed    = 1'b0;
    repeat (200) step();
    tail("after_rst", 400, 30, 1'b0);
    pulse("post_rst", 600, 30);

    // Random widths around and beyond the acceptance window.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) set_inv(1'($urandom_range(0, 1)));
      t   = int'($urandom_range(40, 265));
      jit = int'($urandom_range(0, 2)) - 1;
      pulse("rnd", t * TICK + jit, int'($urandom_range(8, 60)));
    end

    check("never_both", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
